// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N-input, WIDTH-bit operand selector with one registered
// output stage and a 2-entry (head + skid) buffer behind valid/ready
// handshakes. The select is resolved when a beat is accepted; an
// out-of-range select yields zero data plus an error flag, never a stall.
module mux_nx1_pipe #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  // Every select code gets a slot; codes >= NUM_IN map to a zero slot so
  // the index into the channel table can never run off the end.
  localparam int              LP_SLOTS  = 2**SEL_W;
  localparam logic [SEL_W:0]  LP_NUM_IN = (SEL_W+1)'(NUM_IN);

  // State encoding is the (head_valid, skid_valid) pair, so bit 1 is the
  // head valid and bit 0 is the skid valid. (0,1) is never produced.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_head_data;
  logic [SEL_W-1:0] r_head_sel;
  logic             r_head_err;
  logic [WIDTH-1:0] r_skid_data;
  logic [SEL_W-1:0] r_skid_sel;
  logic             r_skid_err;

  logic [WIDTH-1:0] w_chan [LP_SLOTS];
  logic [WIDTH-1:0] w_in_data;
  logic             w_in_err;
  logic             w_accept;
  logic             w_pop;
  logic             w_head_ld_in;
  logic             w_head_ld_skid;
  logic             w_skid_ld;
  logic             w_skid_clr;

  // Unflatten the channel bus; unused select codes read as zero.
  generate
    for (genvar gi = 0; gi < LP_SLOTS; gi++) begin : g_chan
      if (gi < NUM_IN) begin : g_used
        assign w_chan[gi] = in_data[gi*WIDTH +: WIDTH];
      end else begin : g_unused
        assign w_chan[gi] = '0;
      end
    end
  endgenerate

  assign w_in_err  = ({1'b0, in_sel} >= LP_NUM_IN);
  assign w_in_data = w_in_err ? '0 : w_chan[in_sel];

  // in_ready comes straight from the skid-valid flop: no path from out_ready.
  assign in_ready  = ~r_state[0];
  assign out_valid = r_state[1];
  assign out_data  = r_head_data;
  assign out_sel   = r_head_sel;
  assign out_err   = r_head_err;

  assign w_accept  = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Next-state and payload-steering decisions for the head/skid pair.
  always_comb begin
    w_state_next   = r_state;
    w_head_ld_in   = 1'b0;
    w_head_ld_skid = 1'b0;
    w_skid_ld      = 1'b0;
    w_skid_clr     = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_next = ST_ONE;
          w_head_ld_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_pop) begin
          w_head_ld_in = 1'b1;
        end else if (w_accept) begin
          w_state_next = ST_FULL;
          w_skid_ld    = 1'b1;
        end else if (w_pop) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_pop) begin
          w_state_next   = ST_ONE;
          w_head_ld_skid = 1'b1;
          w_skid_clr     = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_EMPTY;
      end
    endcase
  end

  // State register; reset discards any buffered beats.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Payload registers: head loads from the input or from the skid entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head_data <= '0;
      r_head_sel  <= '0;
      r_head_err  <= 1'b0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
      r_skid_err  <= 1'b0;
    end else begin
      if (w_head_ld_in) begin
        r_head_data <= w_in_data;
        r_head_sel  <= in_sel;
        r_head_err  <= w_in_err;
      end else if (w_head_ld_skid) begin
        r_head_data <= r_skid_data;
        r_head_sel  <= r_skid_sel;
        r_head_err  <= r_skid_err;
      end
      if (w_skid_ld) begin
        r_skid_data <= w_in_data;
        r_skid_sel  <= in_sel;
        r_skid_err  <= w_in_err;
      end else if (w_skid_clr) begin
        r_skid_data <= '0;
        r_skid_sel  <= '0;
        r_skid_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: one 4-input instance and one 3-input instance
// share clock and stimulus; a negedge scoreboard tracks both.
module tb_mux_nx1_pipe;

  logic        clk;
  logic        reset_n;
  logic [63:0] in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        out_ready;

  logic [1:0]  rdy;
  logic [1:0]  o_valid;
  logic [1:0]  o_err;
  logic [1:0]  o_sel [2];
  logic [15:0] o_data [2];

  int checks = 0;
  int errors = 0;

  logic [15:0] chan_tbl [4];
  logic [63:0] chan_bus;

  mux_nx1_pipe #(.WIDTH(16), .NUM_IN(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(rdy[0]), .out_data(o_data[0]),
    .out_sel(o_sel[0]), .out_err(o_err[0]), .out_valid(o_valid[0]),
    .out_ready(out_ready)
  );

  mux_nx1_pipe #(.WIDTH(16), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .in_data(in_data[47:0]), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(rdy[1]), .out_data(o_data[1]),
    .out_sel(o_sel[1]), .out_err(o_err[1]), .out_valid(o_valid[1]),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: push the expected beat on acceptance, pop and compare on pop.
  logic [18:0] q0 [$];
  logic [18:0] q1 [$];
  logic [1:0]  stall;
  logic [18:0] held [2];
  int          n_push [2];
  int          n_pop  [2];
  logic [18:0] m_got;
  logic [18:0] m_want;
  logic        m_err;
  int          m_qs;
  int          m_nin;

  always @(negedge clk) begin
    if (!reset_n) begin
      q0.delete();
      q1.delete();
      stall = 2'b00;
      for (int k = 0; k < 2; k++) begin
        n_push[k] = 0;
        n_pop[k]  = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_qs  = (k == 0) ? q0.size() : q1.size();
        m_nin = (k == 0) ? 4 : 3;
        m_got = {o_err[k], o_sel[k], o_data[k]};
        checks++;
        if (o_valid[k] !== (m_qs > 0) || rdy[k] !== (m_qs < 2)) begin
          errors++;
          $display("FAIL occupancy dut%0d: out_valid=%b in_ready=%b, required %b %b (beats held %0d)",
                   k, o_valid[k], rdy[k], (m_qs > 0), (m_qs < 2), m_qs);
        end
        if (stall[k] && o_valid[k]) begin
          checks++;
          if (m_got !== held[k]) begin
            errors++;
            $display("FAIL stable dut%0d: got %h, required %h", k, m_got, held[k]);
          end
        end
        if (o_valid[k] && out_ready && m_qs > 0) begin
          m_want = (k == 0) ? q0.pop_front() : q1.pop_front();
          n_pop[k]++;
          checks++;
          if (m_got !== m_want) begin
            errors++;
            $display("FAIL order dut%0d: got err/sel/data %h, required %h", k, m_got, m_want);
          end
        end
        if (in_valid && rdy[k]) begin
          m_err  = (int'(in_sel) >= m_nin);
          m_want = {m_err, in_sel, m_err ? 16'h0000 : in_data[in_sel*16 +: 16]};
          if (k == 0) q0.push_back(m_want);
          else        q1.push_back(m_want);
          n_push[k]++;
        end
        stall[k] = o_valid[k] && !out_ready;
        held[k]  = m_got;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_valid[k] !== 1'b0 || rdy[k] !== 1'b1 || o_data[k] !== 16'h0 ||
          o_sel[k] !== 2'd0 || o_err[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: valid=%b ready=%b data=%h sel=%0d err=%b, required 0 1 0000 0 0",
                 k, o_valid[k], rdy[k], o_data[k], o_sel[k], o_err[k]);
      end
    end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'(i);
      tick();
      checks++;
      if (o_valid[0] !== 1'b1 || o_data[0] !== chan_tbl[i] || rdy[0] !== 1'b1) begin
        errors++;
        $display("FAIL stream%0d: valid=%b data=%h ready=%b, required 1 %h 1",
                 i, o_valid[0], o_data[0], rdy[0], chan_tbl[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (o_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: out_valid=%b, required 0", o_valid[0]);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    in_sel = 2'd1;
    tick();
    checks++;
    if (rdy[0] !== 1'b0 || o_data[0] !== 16'h1111) begin
      errors++;
      $display("FAIL bp_full: ready=%b data=%h, required 0 1111", rdy[0], o_data[0]);
    end
    // Third beat offered but refused; input changes must not leak in.
    in_sel  = 2'd2;
    in_data = {$urandom, $urandom};
    tick();
    checks++;
    if (rdy[0] !== 1'b0 || o_data[0] !== 16'h1111 || o_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: ready=%b data=%h valid=%b, required 0 1111 1",
               rdy[0], o_data[0], o_valid[0]);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (rdy[0] !== 1'b1 || o_data[0] !== 16'h2222) begin
      errors++;
      $display("FAIL bp_pop1: ready=%b data=%h, required 1 2222", rdy[0], o_data[0]);
    end
    in_data = chan_bus;
    tick();
    checks++;
    if (o_data[0] !== 16'h3333 || o_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_third: data=%h valid=%b, required 3333 1", o_data[0], o_valid[0]);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] want;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_sel   = 2'($urandom_range(0, 3));
      in_data  = {$urandom, $urandom};
      want     = in_data[in_sel*16 +: 16];
      tick();
      checks++;
      if (o_data[0] !== want || rdy[0] !== 1'b1 || o_valid[0] !== 1'b1) begin
        errors++;
        $display("FAIL b2b%0d: data=%h ready=%b valid=%b, required %h 1 1",
                 i, o_data[0], rdy[0], o_valid[0], want);
      end
    end
    in_valid = 1'b0;
    in_data  = chan_bus;
    tick();
  endtask

  task automatic test_out_of_range();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sel    = 2'd3;
    tick();
    checks++;
    if (o_data[1] !== 16'h0 || o_err[1] !== 1'b1 || o_sel[1] !== 2'd3 || o_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL oor_err: data=%h err=%b sel=%0d valid=%b, required 0000 1 3 1",
               o_data[1], o_err[1], o_sel[1], o_valid[1]);
    end
    checks++;
    if (o_data[0] !== 16'h4444 || o_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL oor_inrange4: data=%h err=%b, required 4444 0", o_data[0], o_err[0]);
    end
    in_sel = 2'd1;
    tick();
    checks++;
    if (o_data[1] !== 16'h2222 || o_err[1] !== 1'b0 || o_sel[1] !== 2'd1) begin
      errors++;
      $display("FAIL oor_next: data=%h err=%b sel=%0d, required 2222 0 1",
               o_data[1], o_err[1], o_sel[1]);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'd0;
    tick();
    in_sel = 2'd1;
    tick();
    checks++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL rst_prefull: ready=%b, required 0", rdy[0]);
    end
    in_valid = 1'b0;
    #1 reset_n = 1'b0;
    #1 test_reset();
    tick();
    reset_n  = 1'b1;
    in_valid = 1'b1;
    in_sel   = 2'd2;
    tick();
    checks++;
    if (o_valid[0] !== 1'b1 || o_data[0] !== 16'h3333) begin
      errors++;
      $display("FAIL rst_first_accept: valid=%b data=%h, required 1 3333", o_valid[0], o_data[0]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int n_acc;
    int cyc;
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 10000 && cyc < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom};
      out_ready = 1'($urandom_range(0, 1));
      if (in_valid && rdy[0]) n_acc++;
      cyc++;
      tick();
    end
    checks++;
    if (n_acc < 10000) begin
      errors++;
      $display("FAIL random_budget: accepted %0d beats, required 10000", n_acc);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (n_pop[k] !== n_push[k] || o_valid[k] !== 1'b0) begin
        errors++;
        $display("FAIL drain dut%0d: popped %0d valid=%b, required %0d 0",
                 k, n_pop[k], o_valid[k], n_push[k]);
      end
    end
  endtask

  initial begin
    chan_tbl[0] = 16'h1111;
    chan_tbl[1] = 16'h2222;
    chan_tbl[2] = 16'h3333;
    chan_tbl[3] = 16'h4444;
    chan_bus    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    reset_n   = 1'b0;
    in_data   = chan_bus;
    in_sel    = 2'd0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1 test_reset();
    tick();
    reset_n = 1'b1;
    test_streaming();
    test_backpressure();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
